// File: rtl/clic_timer_src.sv
// rtl/clic_timer_src.sv - periodic/one-shot timer interrupt source for the n_clic controller
// Optional feature macro: TIMER_OVERRUN_EN (8-bit saturating overrun count in STATUS[31:24]).
module clic_timer_src #(
  parameter int CsrAddr      = 'h400,
  parameter int CounterWidth = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        irq_pending,
  input  logic        irq_ack
);

  localparam logic [11:0] AddrCfg = 12'(CsrAddr);
  localparam logic [11:0] AddrCmp = 12'(CsrAddr + 1);
  localparam logic [11:0] AddrSts = 12'(CsrAddr + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic                    cfg_enable;
  logic                    cfg_oneshot;
  logic [3:0]              cfg_psc;
  logic [CounterWidth-1:0] compare;
  logic [CounterWidth-1:0] counter;
  logic [15:0]             prescaler;
  logic [7:0]              overrun;

  logic cfg_wr, cmp_wr, sts_wr;
  logic tick, fire;
  logic [15:0] psc_mask;
  logic unused_inputs;

  assign cfg_wr   = csr_we && (csr_addr == AddrCfg);
  assign cmp_wr   = csr_we && (csr_addr == AddrCmp);
  assign sts_wr   = csr_we && (csr_addr == AddrSts);
  assign psc_mask = (16'd1 << cfg_psc) - 16'd1;
  assign tick     = (state == RUN) && (prescaler == psc_mask);
  assign fire     = tick && (counter == compare);
  assign unused_inputs = ^{csr_wdata, sts_wr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cfg_enable  <= 1'b0;
      cfg_oneshot <= 1'b0;
      cfg_psc     <= 4'd0;
      compare     <= '0;
      counter     <= '0;
      prescaler   <= 16'd0;
      irq_pending <= 1'b0;
    end else begin
      // A CONFIG write overrides whatever the running timer would have done this edge.
      if (cfg_wr) begin
        prescaler   <= 16'd0;
        counter     <= '0;
        cfg_enable  <= csr_wdata[0];
        cfg_oneshot <= csr_wdata[1];
        cfg_psc     <= csr_wdata[7:4];
        state       <= csr_wdata[0] ? RUN : IDLE;
      end else begin
        case (state)
          RUN: begin
            prescaler <= tick ? 16'd0 : prescaler + 16'd1;
            if (tick) counter <= fire ? '0 : counter + CounterWidth'(1);
            if (fire && cfg_oneshot) begin
              cfg_enable <= 1'b0;
              state      <= IDLE;
            end
          end
          default: begin
            prescaler <= 16'd0;
            counter   <= '0;
          end
        endcase
      end

      if (cmp_wr) compare <= csr_wdata[CounterWidth-1:0];

      // A fresh fire replaces an acknowledged request, so fire takes priority over ack.
      if (fire)         irq_pending <= 1'b1;
      else if (irq_ack) irq_pending <= 1'b0;
    end
  end

`ifdef TIMER_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 8'd0;
    end else if (sts_wr) begin
      overrun <= 8'd0;
    end else if (fire && irq_pending && !irq_ack && (overrun != 8'hFF)) begin
      overrun <= overrun + 8'd1;
    end
  end
`else
  assign overrun = 8'd0;
`endif

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      AddrCfg: csr_rdata[7:0] = {cfg_psc, 2'b00, cfg_oneshot, cfg_enable};
      AddrCmp: csr_rdata[CounterWidth-1:0] = compare;
      AddrSts: begin
        csr_rdata[CounterWidth-1:0] = counter;
        csr_rdata[31:24]            = overrun;
      end
      default: csr_rdata = 32'd0;
    endcase
  end

endmodule
